// File: rtl/lc3_reg_file_if.sv
// Register-file port bundle for the LC3 datapath: two read ports, one write port, NZP flags.
// The master (datapath control) drives selects and write strobes; the slave (register file) returns data and flags.
interface lc3_reg_file_if #(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 16,
  parameter int SEL_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
);
  // ld_reg/ld_cc are single-cycle strobes sampled on the rising edge; there is
  // no valid/ready pair because the register file accepts every request
  // (it never stalls) and reads are combinational with no request phase.
  logic [SEL_W-1:0]  sr1_sel;
  logic [SEL_W-1:0]  sr2_sel;
  logic [DATA_W-1:0] sr1_out;
  logic [DATA_W-1:0] sr2_out;
  logic [SEL_W-1:0]  dr_sel;
  logic [DATA_W-1:0] wr_data;
  logic              ld_reg;
  logic              ld_cc;
  logic              n;
  logic              z;
  logic              p;

  modport master (
    output sr1_sel, sr2_sel, dr_sel, wr_data, ld_reg, ld_cc,
    input  sr1_out, sr2_out, n, z, p
  );

  modport slave (
    input  sr1_sel, sr2_sel, dr_sel, wr_data, ld_reg, ld_cc,
    output sr1_out, sr2_out, n, z, p
  );
endinterface

// File: rtl/lc3_reg_file.sv
// LC3 general-purpose register file with NZP condition codes; combinational reads, registered writes.
// Define REGFILE_BYPASS_EN to forward wr_data onto a read port that selects the register being written.
module lc3_reg_file #(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  lc3_reg_file_if.slave    rf
);
  localparam int SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] sr1_q;
  logic [DATA_W-1:0] sr2_q;
  logic              sr1_fwd;
  logic              sr2_fwd;
  logic [2:0]        nzp_q;
  logic              n_next;
  logic              z_next;
  logic              p_next;

  // Writes to an index with no backing register match no entry and are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (rf.ld_reg) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (rf.dr_sel == SEL_W'(i)) begin
          regs[i] <= rf.wr_data;
        end
      end
    end
  end

  // Read muxes default to zero so out-of-range selects read back as 0.
  always_comb begin
    sr1_q = '0;
    sr2_q = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rf.sr1_sel == SEL_W'(i)) sr1_q = regs[i];
      if (rf.sr2_sel == SEL_W'(i)) sr2_q = regs[i];
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic dr_in_range;

  always_comb begin
    dr_in_range = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rf.dr_sel == SEL_W'(i)) dr_in_range = 1'b1;
    end
  end

  assign sr1_fwd = !rst && rf.ld_reg && dr_in_range && (rf.dr_sel == rf.sr1_sel);
  assign sr2_fwd = !rst && rf.ld_reg && dr_in_range && (rf.dr_sel == rf.sr2_sel);
`else
  assign sr1_fwd = 1'b0;
  assign sr2_fwd = 1'b0;
`endif

  assign rf.sr1_out = sr1_fwd ? rf.wr_data : sr1_q;
  assign rf.sr2_out = sr2_fwd ? rf.wr_data : sr2_q;

  // Flags are derived from the raw bus value, independent of whether it lands in a register.
  assign n_next = rf.wr_data[DATA_W-1];
  assign z_next = (rf.wr_data == '0);
  assign p_next = !n_next && !z_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nzp_q <= 3'b010;
    end else if (rf.ld_cc) begin
      nzp_q <= {n_next, z_next, p_next};
    end
  end

  assign rf.n = nzp_q[2];
  assign rf.z = nzp_q[1];
  assign rf.p = nzp_q[0];
endmodule

// File: tb/tb_lc3_reg_file.sv
// Directed bench for lc3_reg_file: reset, write latency, CC encoding, dual writes, last-write-wins, full sweep.
// Inputs change at negedge or mid-cycle; outputs are sampled 1 ns after the rising edge or between edges.
module tb_lc3_reg_file;
  localparam int NUM_REGS = 8;
  localparam int DATA_W   = 16;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] sweep_val [NUM_REGS];
  logic [DATA_W-1:0] same_cycle_exp;

  lc3_reg_file_if #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W)) rf_if ();

  lc3_reg_file #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .rf  (rf_if)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic drive(input logic ld_reg, input logic ld_cc,
                       input logic [2:0] dr, input logic [DATA_W-1:0] wr);
    rf_if.ld_reg  = ld_reg;
    rf_if.ld_cc   = ld_cc;
    rf_if.dr_sel  = dr;
    rf_if.wr_data = wr;
  endtask

  task automatic sel(input logic [2:0] s1, input logic [2:0] s2);
    rf_if.sr1_sel = s1;
    rf_if.sr2_sel = s2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard check
  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] nzp();
    return {13'd0, rf_if.n, rf_if.z, rf_if.p};
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    drive(1'b0, 1'b0, 3'd0, 16'h0000);
    sel(3'd0, 3'd0);
    #2;
    check("reset_sr1", rf_if.sr1_out, 16'h0000);
    check("reset_nzp", nzp(), 16'h0002);

    @(negedge clk);
    rst = 1'b0;

    // R3 = 0x1234 with CC load, then asynchronous reset mid-cycle
    drive(1'b1, 1'b1, 3'd3, 16'h1234);
    sel(3'd3, 3'd3);
    tick();
    drive(1'b0, 1'b0, 3'd0, 16'h0000);
    #1;
    check("r3_written", rf_if.sr1_out, 16'h1234);
    check("r3_cc_pos", nzp(), 16'h0001);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_sr1", rf_if.sr1_out, 16'h0000);
    check("async_rst_nzp", nzp(), 16'h0002);
    drive(1'b1, 1'b1, 3'd3, 16'hAAAA);
    tick();
    check("rst_blocks_ld_reg", rf_if.sr1_out, 16'h0000);
    check("rst_blocks_ld_cc", nzp(), 16'h0002);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 3'd0, 16'h0000);

    // R5 = 0xBEEF, same-cycle and next-cycle reads on both ports
    @(negedge clk);
    drive(1'b1, 1'b0, 3'd5, 16'hBEEF);
    sel(3'd5, 3'd5);
    #1;
`ifdef REGFILE_BYPASS_EN
    same_cycle_exp = 16'hBEEF;
`else
    same_cycle_exp = 16'h0000;
`endif
    check("r5_same_cycle_sr1", rf_if.sr1_out, same_cycle_exp);
    check("r5_same_cycle_sr2", rf_if.sr2_out, same_cycle_exp);
    tick();
    drive(1'b0, 1'b0, 3'd0, 16'h0000);
    #1;
    check("r5_after_sr1", rf_if.sr1_out, 16'hBEEF);
    check("r5_after_sr2", rf_if.sr2_out, 16'hBEEF);

    // CC only: 0x8000 -> N, 0x0000 -> Z, 0x0001 -> P, registers untouched
    @(negedge clk);
    sel(3'd5, 3'd0);
    drive(1'b0, 1'b1, 3'd0, 16'h8000);
    tick();
    check("cc_neg", nzp(), 16'h0004);
    check("cc_only_r5", rf_if.sr1_out, 16'hBEEF);
    check("cc_only_r0", rf_if.sr2_out, 16'h0000);
    drive(1'b0, 1'b1, 3'd0, 16'h0000);
    tick();
    check("cc_zero", nzp(), 16'h0002);
    drive(1'b0, 1'b1, 3'd0, 16'h0001);
    tick();
    check("cc_pos", nzp(), 16'h0001);
    drive(1'b0, 1'b1, 3'd0, 16'h7FFF);
    tick();
    check("cc_pos_max", nzp(), 16'h0001);

    // ld_reg and ld_cc together
    @(negedge clk);
    sel(3'd7, 3'd7);
    drive(1'b1, 1'b1, 3'd7, 16'hFFFF);
    tick();
    drive(1'b0, 1'b0, 3'd0, 16'h0000);
    #1;
    check("dual_r7", rf_if.sr1_out, 16'hFFFF);
    check("dual_nzp", nzp(), 16'h0004);

    // Back-to-back writes to R1, then a non-write with data on the bus
    @(negedge clk);
    sel(3'd0, 3'd1);
    drive(1'b1, 1'b0, 3'd1, 16'h0001);
    tick();
    check("r1_first", rf_if.sr2_out, 16'h0001);
    drive(1'b1, 1'b0, 3'd1, 16'h0002);
    tick();
    drive(1'b0, 1'b0, 3'd1, 16'h5555);
    #1;
    check("r1_last_wins", rf_if.sr2_out, 16'h0002);
    tick();
    check("r1_no_ld_reg", rf_if.sr2_out, 16'h0002);

    // Sweep all registers; ld_cc stays low so NZP must hold at N
    @(negedge clk);
    for (int i = 0; i < NUM_REGS; i++) begin
      sweep_val[i] = 16'h1000 * (i + 1) + 16'h0011 * i + 16'h0A00;
      exp_q.push_back(sweep_val[i]);
      drive(1'b1, 1'b0, 3'(i), sweep_val[i]);
      tick();
    end
    drive(1'b0, 1'b0, 3'd0, 16'h0000);
    for (int i = 0; i < NUM_REGS; i++) begin
      sel(3'(i), 3'(NUM_REGS - 1 - i));
      #1;
      check($sformatf("sweep_sr1_r%0d", i), rf_if.sr1_out, exp_q.pop_front());
      check($sformatf("sweep_sr2_r%0d", NUM_REGS - 1 - i), rf_if.sr2_out,
            sweep_val[NUM_REGS - 1 - i]);
    end
    check("sweep_nzp_hold", nzp(), 16'h0004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
